// File: rtl/constraint_eval_seq.sv
// Sequential constraint-table checker: one assignment per transaction, one constraint per cycle.
// Optional CONSTRAINT_EARLY_EXIT_EN stops evaluation at the first false constraint.
module constraint_eval_seq #(
   parameter int NVAR = 32,
   parameter int VW = 32,
   parameter int NCON = 32,
   localparam int IW = $clog2(NVAR),
   localparam int CW = $clog2(NCON + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [CW-1:0]      cfg_addr,
   input  logic [3:0]         cfg_op,
   input  logic [IW-1:0]      cfg_a,
   input  logic [IW-1:0]      cfg_b,
   input  logic [VW-1:0]      cfg_k,
   input  logic [CW-1:0]      cfg_ncon,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NVAR*VW-1:0] in_vars,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sat,
   output logic [CW-1:0]      out_fail_cnt,
   output logic [CW-1:0]      out_first_fail,
   output logic [15:0]        stat_pass_cnt
);
   localparam int AW = (NCON > 1) ? $clog2(NCON) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

   typedef struct packed {
      logic [3:0]    op;
      logic [IW-1:0] a;
      logic [IW-1:0] b;
      logic [VW-1:0] k;
   } entry_t;

   localparam entry_t TRUE_ENTRY = '{op: 4'hB, a: '0, b: '0, k: '0};

   // Out-of-range indices fall through the loop and read as zero.
   function automatic logic [VW-1:0] var_at(input logic [NVAR*VW-1:0] v, input logic [IW-1:0] i);
      var_at = '0;
      for (int n = 0; n < NVAR; n++)
         if (int'(i) == n) var_at = v[n*VW +: VW];
   endfunction

   function automatic logic eval_entry(input entry_t e, input logic [NVAR*VW-1:0] v);
      logic [VW-1:0] a, b, t;
      a = var_at(v, e.a);
      b = var_at(v, e.b);
      t = '0;
      eval_entry = 1'b0;
      case (e.op)
         4'd0:  begin t = a * b; eval_entry = |t; end
         4'd1:  eval_entry = (a == '0) || (b != '0);
         4'd2:  eval_entry = (a != '0) || (b != '0);
         4'd3:  eval_entry = (a != b);
         4'd4:  begin t = a - b; eval_entry = |t; end
         4'd5:  eval_entry = (a != e.k);
         4'd6:  eval_entry = ((a & e.k) != b);
         4'd7:  begin t = a + b; eval_entry = (t == '0); end
         4'd8:  eval_entry = |(a | b);
         4'd9:  eval_entry = |(~a | b);
         4'd10: begin t = a + e.k; eval_entry = |t; end
         4'd11: eval_entry = 1'b1;
         4'd12: begin t = a >> e.k[4:0]; eval_entry = (|t) && (|b); end
         default: eval_entry = 1'b0;
      endcase
   endfunction

   state_t              state_q, state_d;
   entry_t              tbl_q [NCON];
   entry_t              tbl_d [NCON];
   logic [NVAR*VW-1:0]  vars_q, vars_d;
   logic [CW-1:0]       ncon_q, ncon_d, idx_q, idx_d;
   logic [CW-1:0]       fail_cnt_q, fail_cnt_d, first_fail_q, first_fail_d;
   logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
   logic [CW-1:0]       out_fail_cnt_q, out_fail_cnt_d, out_first_fail_q, out_first_fail_d;
   logic [15:0]         stat_pass_cnt_q, stat_pass_cnt_d;
   logic [CW-1:0]       ncon_in;
   logic                cur_true, done_now;

   always_comb begin
      state_d          = state_q;
      tbl_d            = tbl_q;
      vars_d           = vars_q;
      ncon_d           = ncon_q;
      idx_d            = idx_q;
      fail_cnt_d       = fail_cnt_q;
      first_fail_d     = first_fail_q;
      in_ready_d       = in_ready_q;
      out_valid_d      = out_valid_q;
      out_sat_d        = out_sat_q;
      out_fail_cnt_d   = out_fail_cnt_q;
      out_first_fail_d = out_first_fail_q;
      stat_pass_cnt_d  = stat_pass_cnt_q;
      done_now         = 1'b0;
      ncon_in          = (cfg_ncon > CW'(NCON)) ? CW'(NCON) : cfg_ncon;
      cur_true         = eval_entry(tbl_q[idx_q[AW-1:0]], vars_q);

      case (state_q)
         S_IDLE: begin
            // The table write lands before the first EVAL cycle, so an accept
            // in the same cycle already sees it.
            if (cfg_we && (int'(cfg_addr) < NCON))
               tbl_d[cfg_addr[AW-1:0]] = '{op: cfg_op, a: cfg_a, b: cfg_b, k: cfg_k};
            if (in_valid) begin
               vars_d       = in_vars;
               ncon_d       = ncon_in;
               idx_d        = '0;
               fail_cnt_d   = '0;
               first_fail_d = '0;
               in_ready_d   = 1'b0;
               if (ncon_in == '0) begin
                  state_d          = S_DONE;
                  out_valid_d      = 1'b1;
                  out_sat_d        = 1'b1;
                  out_fail_cnt_d   = '0;
                  out_first_fail_d = '0;
               end else begin
                  state_d = S_EVAL;
               end
            end
         end
         S_EVAL: begin
            if (!cur_true) begin
               fail_cnt_d = fail_cnt_q + 1'b1;
               if (fail_cnt_q == '0) first_fail_d = idx_q;
`ifdef CONSTRAINT_EARLY_EXIT_EN
               done_now = 1'b1;
`endif
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == ncon_q - 1'b1) done_now = 1'b1;
            if (done_now) begin
               state_d          = S_DONE;
               out_valid_d      = 1'b1;
               out_sat_d        = (fail_cnt_d == '0);
               out_fail_cnt_d   = fail_cnt_d;
               out_first_fail_d = (fail_cnt_d == '0) ? ncon_q : first_fail_d;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               if (out_sat_q && (stat_pass_cnt_q != 16'hFFFF))
                  stat_pass_cnt_d = stat_pass_cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         for (int i = 0; i < NCON; i++) tbl_q[i] <= TRUE_ENTRY;
         vars_q           <= '0;
         ncon_q           <= '0;
         idx_q            <= '0;
         fail_cnt_q       <= '0;
         first_fail_q     <= '0;
         in_ready_q       <= 1'b1;
         out_valid_q      <= 1'b0;
         out_sat_q        <= 1'b0;
         out_fail_cnt_q   <= '0;
         out_first_fail_q <= '0;
         stat_pass_cnt_q  <= '0;
      end else begin
         state_q          <= state_d;
         tbl_q            <= tbl_d;
         vars_q           <= vars_d;
         ncon_q           <= ncon_d;
         idx_q            <= idx_d;
         fail_cnt_q       <= fail_cnt_d;
         first_fail_q     <= first_fail_d;
         in_ready_q       <= in_ready_d;
         out_valid_q      <= out_valid_d;
         out_sat_q        <= out_sat_d;
         out_fail_cnt_q   <= out_fail_cnt_d;
         out_first_fail_q <= out_first_fail_d;
         stat_pass_cnt_q  <= stat_pass_cnt_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_sat        = out_sat_q;
   assign out_fail_cnt   = out_fail_cnt_q;
   assign out_first_fail = out_first_fail_q;
   assign stat_pass_cnt  = stat_pass_cnt_q;
endmodule

// File: tb/tb_constraint_eval_seq.sv
// Directed bench for constraint_eval_seq (NVAR=4, VW=8, NCON=8); scoreboard of expected results.
module tb_constraint_eval_seq;
   localparam int NVAR = 4;
   localparam int VW = 8;
   localparam int NCON = 8;
   localparam int IW = 2;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_we = 1'b0;
   logic [CW-1:0]     cfg_addr = '0;
   logic [3:0]        cfg_op = '0;
   logic [IW-1:0]     cfg_a = '0;
   logic [IW-1:0]     cfg_b = '0;
   logic [VW-1:0]     cfg_k = '0;
   logic [CW-1:0]     cfg_ncon = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NVAR*VW-1:0] in_vars = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_sat;
   logic [CW-1:0]     out_fail_cnt;
   logic [CW-1:0]     out_first_fail;
   logic [15:0]       stat_pass_cnt;

   typedef struct {
      logic          sat;
      logic [CW-1:0] fc;
      logic [CW-1:0] ff;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_stat = 0;

   constraint_eval_seq #(.NVAR(NVAR), .VW(VW), .NCON(NCON)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op), .cfg_a(cfg_a),
      .cfg_b(cfg_b), .cfg_k(cfg_k), .cfg_ncon(cfg_ncon),
      .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
      .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
      .out_fail_cnt(out_fail_cnt), .out_first_fail(out_first_fail),
      .stat_pass_cnt(stat_pass_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic prog(input int addr, input int op, input int a, input int b, input int k);
      cfg_we = 1'b1; cfg_addr = CW'(addr); cfg_op = 4'(op);
      cfg_a = IW'(a); cfg_b = IW'(b); cfg_k = VW'(k);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // ncon_eff: clamped count; fc_full: false constraints among the first ncon_eff; ff: lowest false index.
   task automatic send(input string tag, input logic [31:0] vars, input int ncon_raw,
                       input int ncon_eff, input int fc_full, input int ff);
      exp_t e;
      int lat;
      if (fc_full == 0) begin
         e.sat = 1'b1; e.fc = '0; e.ff = CW'(ncon_eff); e.lat = ncon_eff + 1;
      end else begin
         e.sat = 1'b0; e.ff = CW'(ff);
`ifdef CONSTRAINT_EARLY_EXIT_EN
         e.fc = CW'(1); e.lat = ff + 2;
`else
         e.fc = CW'(fc_full); e.lat = ncon_eff + 1;
`endif
      end
      sb.push_back(e);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_vars = vars; cfg_ncon = CW'(ncon_raw);
      @(negedge clk);
      in_valid = 1'b0; cfg_we = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_sat"}, 32'(out_sat), 32'(e.sat));
      chk({tag, "_fail_cnt"}, 32'(out_fail_cnt), 32'(e.fc));
      chk({tag, "_first_fail"}, 32'(out_first_fail), 32'(e.ff));
   endtask

   task automatic collect(input string tag);
      if (out_sat && exp_stat < 16'hFFFF) exp_stat++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(in_ready), 32'd1);
      chk({tag, "_stat"}, 32'(stat_pass_cnt), 32'(exp_stat));
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sat", 32'(out_sat), 32'd0);
      chk("rst_fail_cnt", 32'(out_fail_cnt), 32'd0);
      chk("rst_first_fail", 32'(out_first_fail), 32'd0);
      chk("rst_stat", 32'(stat_pass_cnt), 32'd0);

      send("ncon0", 32'hDEADBEEF, 0, 0, 0, 0);
      collect("ncon0");

      prog(0, 5, 0, 0, 8'hB8);
      prog(1, 0, 0, 1, 0);
      send("nek_mul_sat", 32'h0000_0503, 2, 2, 0, 0);
      collect("nek_mul_sat");
      send("nek_fail", 32'h0000_05B8, 2, 2, 1, 0);
      collect("nek_fail");
      send("mul_wrap", 32'h0000_1010, 2, 2, 1, 1);
      collect("mul_wrap");

      prog(0, 7, 0, 1, 0);
      send("nadd_true", 32'h0000_01FF, 1, 1, 0, 0);
      collect("nadd_true");
      send("nadd_false", 32'h0000_02FF, 1, 1, 1, 0);
      collect("nadd_false");

      // Clamp 15 -> 8, with entry 5 made false in the accept cycle itself.
      cfg_we = 1'b1; cfg_addr = 4'd5; cfg_op = 4'd13; cfg_a = '0; cfg_b = '0; cfg_k = '0;
      send("clamp_samecyc", 32'h0000_01FF, 15, 8, 1, 5);
      collect("clamp_samecyc");

      prog(5, 11, 0, 0, 0);
      prog(12, 13, 0, 0, 0);
      send("addr_oob", 32'h0000_01FF, 8, 8, 0, 0);
      collect("addr_oob");

      // Backpressure: results hold and writes in DONE are dropped.
      send("bp", 32'h0000_02FF, 2, 2, 1, 0);
      for (int i = 0; i < 5; i++) begin
         cfg_we = 1'b1; cfg_addr = 4'd0; cfg_op = 4'd11;
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_sat", 32'(out_sat), 32'd0);
         chk("bp_fail_cnt", 32'(out_fail_cnt), 32'd1);
         chk("bp_first_fail", 32'(out_first_fail), 32'd0);
      end
      cfg_we = 1'b0;
      collect("bp");
      send("bp_table_kept", 32'h0000_02FF, 2, 2, 1, 0);
      collect("bp_table_kept");

      prog(0, 7, 0, 1, 0);
      prog(1, 3, 0, 0, 0);
      prog(3, 14, 0, 0, 0);
      send("early_exit", 32'h0000_01FF, 4, 4, 2, 1);
      collect("early_exit");

      // Reset in the middle of evaluation abandons the transaction.
      in_valid = 1'b1; in_vars = 32'h0000_01FF; cfg_ncon = 4'd8;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #2;
      exp_stat = 0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_stat", 32'(stat_pass_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("mid_rst_no_result", 32'(n), 32'd0);
      send("table_restored", 32'h0000_1010, 8, 8, 0, 0);
      collect("table_restored");

      prog(0, 1, 0, 1, 0);
      prog(1, 12, 2, 3, 3);
      prog(2, 6, 0, 1, 8'h0F);
      prog(3, 9, 2, 3, 0);
      prog(4, 10, 3, 0, 1);
      prog(5, 4, 0, 1, 0);
      prog(6, 8, 2, 3, 0);
      prog(7, 2, 2, 3, 0);
      send("op_mix", 32'hFF08_0F1F, 8, 8, 2, 2);
      collect("op_mix");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
